// File: rtl/sm_poly_eval.sv
// Multi-cycle polynomial evaluator using Horner's rule, one multiply-accumulate per clock.
// Start/done handshake, per-request negative pass-through mode and a per-request overflow flag.
module sm_poly_eval #(
  parameter int XW    = 16,
  parameter int YW    = 32,
  parameter int CW    = 16,
  parameter int ORDER = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      mode,
  input  logic [XW-1:0]             x_in,
  input  logic [(ORDER+1)*CW-1:0]   coef,
  output logic                      busy,
  output logic                      done,
  output logic [YW-1:0]             y_out,
  output logic                      ovf
);

  localparam int FW = YW + XW + 1;
  localparam int KW = (ORDER > 1) ? $clog2(ORDER) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state_r;
  logic signed [XW-1:0]      x_r;
  logic [(ORDER+1)*CW-1:0]   coef_r;
  logic signed [YW-1:0]      acc_r;
  logic [KW-1:0]             k_r;
  logic                      ovf_int_r;

  logic signed [CW-1:0]      coef_k_s;
  logic signed [FW-1:0]      full_s;
  logic                      step_ovf_s;

  // True when the exact Horner result does not survive truncation to YW bits.
  function automatic logic wrap_ovf(input logic signed [FW-1:0] full);
    logic [FW-1:0] resext;
    resext = {{(FW-YW){full[YW-1]}}, full[YW-1:0]};
    return (full != resext);
  endfunction

  // One Horner step at full precision: acc*x + c[k], with the truncation check.
  always_comb begin
    coef_k_s   = coef_r[k_r*CW +: CW];
    full_s     = FW'(acc_r) * FW'(x_r) + FW'(coef_k_s);
    step_ovf_s = wrap_ovf(full_s);
  end

  // Control FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      x_r       <= {XW{1'b0}};
      coef_r    <= {((ORDER+1)*CW){1'b0}};
      acc_r     <= {YW{1'b0}};
      k_r       <= {KW{1'b0}};
      ovf_int_r <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      y_out     <= {YW{1'b0}};
      ovf       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            x_r       <= x_in;
            coef_r    <= coef;
            busy      <= 1'b1;
            ovf_int_r <= 1'b0;
            // Piecewise mode passes negative operands straight through.
            if (mode && x_in[XW-1]) begin
              acc_r   <= YW'($signed(x_in));
              state_r <= DONE;
            end else begin
              acc_r   <= YW'($signed(coef[ORDER*CW +: CW]));
              k_r     <= KW'(ORDER - 1);
              state_r <= CALC;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        CALC: begin
          acc_r     <= full_s[YW-1:0];
          ovf_int_r <= ovf_int_r | step_ovf_s;
          if (k_r == {KW{1'b0}}) begin
            state_r <= DONE;
          end else begin
            k_r <= k_r - KW'(1);
          end
        end
        DONE: begin
          // First cycle publishes the result; the second retires to IDLE.
          if (!done) begin
            y_out <= acc_r;
            ovf   <= ovf_int_r;
            done  <= 1'b1;
          end else begin
            done    <= 1'b0;
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm_poly_eval.sv
// Directed self-checking bench for sm_poly_eval (ORDER=2, XW=16, YW=32, CW=16).
module tb_sm_poly_eval;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mode;
  logic [15:0] x_in;
  logic [47:0] coef;
  logic        busy;
  logic        done;
  logic [31:0] y_out;
  logic        ovf;

  int total;
  int bad;

  sm_poly_eval #(.XW(16), .YW(32), .CW(16), .ORDER(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .x_in  (x_in),
    .coef  (coef),
    .busy  (busy),
    .done  (done),
    .y_out (y_out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and watch 8 cycles; reports first-done latency, result and done count.
  task automatic run_req(input logic signed [15:0] x, input logic signed [15:0] c2,
                         input logic signed [15:0] c1, input logic signed [15:0] c0,
                         input logic m, output int lat, output int ndone,
                         output logic signed [31:0] y, output logic o, output logic b0);
    x_in  = x;
    coef  = {c2, c1, c0};
    mode  = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    b0    = busy;
    lat   = -1;
    ndone = 0;
    y     = 32'sd0;
    o     = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = i;
          y   = y_out;
          o   = ovf;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0; x_in = 16'd0; coef = 48'd0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)   begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (y_out !== 32'd0) begin bad++; $display("FAIL reset_y got=%0d exp=0", y_out); end
    total++; if (ovf !== 1'b0)    begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_poly();
    int lat, nd; logic signed [31:0] y; logic o, b0;
    run_req(16'sd10, 16'sd0, 16'sd3, 16'sd8, 1'b0, lat, nd, y, o, b0);
    total++; if (y !== 32'sd38)  begin bad++; $display("FAIL poly_y got=%0d exp=38", y); end
    total++; if (o !== 1'b0)     begin bad++; $display("FAIL poly_ovf got=%b exp=0", o); end
    total++; if (lat != 3)       begin bad++; $display("FAIL poly_lat got=%0d exp=3", lat); end
    total++; if (nd != 1)        begin bad++; $display("FAIL poly_ndone got=%0d exp=1", nd); end
    total++; if (b0 !== 1'b1)    begin bad++; $display("FAIL poly_busy got=%b exp=1", b0); end
  endtask

  task automatic test_bypass();
    int lat, nd; logic signed [31:0] y; logic o, b0;
    run_req(-16'sd4, 16'sd0, 16'sd3, 16'sd8, 1'b1, lat, nd, y, o, b0);
    total++; if (y !== -32'sd4)  begin bad++; $display("FAIL byp_y got=%0d exp=-4", y); end
    total++; if (lat != 1)       begin bad++; $display("FAIL byp_lat got=%0d exp=1", lat); end
    total++; if (o !== 1'b0)     begin bad++; $display("FAIL byp_ovf got=%b exp=0", o); end
    run_req(-16'sd4, 16'sd0, 16'sd3, 16'sd8, 1'b0, lat, nd, y, o, b0);
    total++; if (y !== -32'sd4)  begin bad++; $display("FAIL negpoly_y got=%0d exp=-4", y); end
    total++; if (lat != 3)       begin bad++; $display("FAIL negpoly_lat got=%0d exp=3", lat); end
    // Piecewise mode with non-negative x still evaluates the polynomial.
    run_req(16'sd10, 16'sd0, 16'sd3, 16'sd8, 1'b1, lat, nd, y, o, b0);
    total++; if (y !== 32'sd38)  begin bad++; $display("FAIL pwpos_y got=%0d exp=38", y); end
    total++; if (lat != 3)       begin bad++; $display("FAIL pwpos_lat got=%0d exp=3", lat); end
  endtask

  task automatic test_square();
    int lat, nd; logic signed [31:0] y; logic o, b0;
    run_req(-16'sd300, 16'sd1, 16'sd0, 16'sd0, 1'b0, lat, nd, y, o, b0);
    total++; if (y !== 32'sd90000) begin bad++; $display("FAIL sq_y got=%0d exp=90000", y); end
    total++; if (o !== 1'b0)       begin bad++; $display("FAIL sq_ovf got=%b exp=0", o); end
    run_req(16'sd0, 16'sd1, 16'sd0, -16'sd7, 1'b0, lat, nd, y, o, b0);
    total++; if (y !== -32'sd7)    begin bad++; $display("FAIL x0_y got=%0d exp=-7", y); end
  endtask

  task automatic test_ovf();
    int lat, nd; logic signed [31:0] y; logic o, b0;
    run_req(16'sd32767, 16'sd32767, 16'sd0, 16'sd0, 1'b0, lat, nd, y, o, b0);
    total++; if (o !== 1'b1)            begin bad++; $display("FAIL ovf_flag got=%b exp=1", o); end
    total++; if (y !== 32'sd1073840127) begin bad++; $display("FAIL ovf_y got=%0d exp=1073840127", y); end
    run_req(16'sd10, 16'sd0, 16'sd3, 16'sd8, 1'b0, lat, nd, y, o, b0);
    total++; if (o !== 1'b0)            begin bad++; $display("FAIL ovf_clear got=%b exp=0", o); end
    total++; if (y !== 32'sd38)         begin bad++; $display("FAIL ovf_next_y got=%0d exp=38", y); end
  endtask

  task automatic test_ignore();
    int lat, nd; logic signed [31:0] y;
    x_in = 16'sd2; coef = {16'sd0, 16'sd3, 16'sd8}; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    // Second request during CALC with different operands must be dropped.
    x_in = 16'sd5; coef = {16'sd1, 16'sd1, 16'sd1}; mode = 1'b1;
    lat = -1; nd = 0; y = 32'sd0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        nd++;
        if (lat < 0) begin lat = i; y = y_out; end
      end
    end
    total++; if (nd != 1)        begin bad++; $display("FAIL ign_ndone got=%0d exp=1", nd); end
    total++; if (y !== 32'sd14)  begin bad++; $display("FAIL ign_y got=%0d exp=14", y); end
    total++; if (lat != 3)       begin bad++; $display("FAIL ign_lat got=%0d exp=3", lat); end
  endtask

  task automatic test_back_to_back();
    int lat; logic seen;
    x_in = 16'sd10; coef = {16'sd0, 16'sd3, 16'sd8}; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL b2b_first_done got=%b exp=1", seen); end
    x_in = -16'sd300; coef = {16'sd1, 16'sd0, 16'sd0}; start = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept_busy got=%b exp=1", busy); end
    lat = -1;
    for (int i = 1; i <= 8 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (done) lat = i;
    end
    total++; if (lat != 3)         begin bad++; $display("FAIL b2b_lat got=%0d exp=3", lat); end
    total++; if (y_out !== 32'sd90000) begin bad++; $display("FAIL b2b_y got=%0d exp=90000", y_out); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_abort();
    int lat, nd; logic signed [31:0] y; logic o, b0;
    run_req(16'sd32767, 16'sd32767, 16'sd0, 16'sd0, 1'b0, lat, nd, y, o, b0);
    x_in = 16'sd10; coef = {16'sd0, 16'sd3, 16'sd8}; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (y_out !== 32'd0) begin bad++; $display("FAIL abort_y got=%0d exp=0", y_out); end
    total++; if (ovf !== 1'b0)    begin bad++; $display("FAIL abort_ovf got=%b exp=0", ovf); end
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    total++; if (nd != 0)         begin bad++; $display("FAIL abort_ndone got=%0d exp=0", nd); end
    run_req(-16'sd4, 16'sd0, 16'sd3, 16'sd8, 1'b0, lat, nd, y, o, b0);
    total++; if (y !== -32'sd4)   begin bad++; $display("FAIL abort_next_y got=%0d exp=-4", y); end
    total++; if (lat != 3)        begin bad++; $display("FAIL abort_next_lat got=%0d exp=3", lat); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    x_in  = 16'd0;
    coef  = 48'd0;
    test_reset();
    test_poly();
    test_bypass();
    test_square();
    test_ovf();
    test_ignore();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
